// File: rtl/instr_enc_pkg.sv
// Shared constants, types and helpers for the RV32I instruction encoder.
// Holds opcodes, request-class codes, the NOP word and the loader FSM state type.
package instr_enc_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned KIND_W   = 3;
   localparam int unsigned ALU_OP_W = 4;
   localparam int unsigned REG_W    = 5;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [KIND_W-1:0] KIND_R    = 3'd0;
   localparam logic [KIND_W-1:0] KIND_I    = 3'd1;
   localparam logic [KIND_W-1:0] KIND_B    = 3'd2;
   localparam logic [KIND_W-1:0] KIND_JALR = 3'd3;
   localparam logic [KIND_W-1:0] KIND_JAL  = 3'd4;

   localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_DONE = 1'b1
   } enc_state_e;

   // Field-level request as seen by the format packer.
   typedef struct packed {
      logic [KIND_W-1:0]   kind;
      logic [ALU_OP_W-1:0] alu_op;
      logic [REG_W-1:0]    rd;
      logic [REG_W-1:0]    rs1;
      logic [REG_W-1:0]    rs2;
      logic [XLEN-1:0]     imm;
   } enc_req_t;

   // True when v is representable as an nbits-wide two's-complement value.
   function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned nbits);
      logic [XLEN-1:0] s;
      s = XLEN'($signed(v) >>> (nbits - 1));
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-level request handshake between a program source and the encoder.
interface instr_encoder_if;
   import instr_enc_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [KIND_W-1:0]   in_kind;
   logic [ALU_OP_W-1:0] in_alu_op;
   logic [REG_W-1:0]    in_rd;
   logic [REG_W-1:0]    in_rs1;
   logic [REG_W-1:0]    in_rs2;
   logic [XLEN-1:0]     in_imm;
   logic                in_last;

   modport master (
      output in_valid, in_kind, in_alu_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_kind, in_alu_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
      output in_ready
   );

endinterface

// File: rtl/instr_format_pack.sv
// Combinational RV32I format packer: request fields in, encoded word and legality out.
// Any illegal request is replaced by the canonical NOP.
module instr_format_pack
   import instr_enc_pkg::*;
(
   input  enc_req_t        req,
   output logic [XLEN-1:0] word_c,
   output logic            illegal_c
);

   logic [2:0]      f3;
   logic            f7b;
   logic [XLEN-1:0] imm;
   logic            is_shift;

   assign f3       = req.alu_op[2:0];
   assign f7b      = req.alu_op[3];
   assign imm      = req.imm;
   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

   always_comb begin
      word_c    = NOP_WORD;
      illegal_c = 1'b0;
      case (req.kind)
         KIND_R: begin
            word_c    = {1'b0, f7b, 5'b0, req.rs2, req.rs1, f3, req.rd, OP_R};
            illegal_c = f7b && !((f3 == 3'b000) || (f3 == 3'b101));
         end
         KIND_I: begin
            if (is_shift) begin
               word_c    = {1'b0, f7b, 5'b0, imm[4:0], req.rs1, f3, req.rd, OP_I};
               illegal_c = (imm[XLEN-1:5] != '0) || (f7b && (f3 != 3'b101));
            end else begin
               word_c    = {imm[11:0], req.rs1, f3, req.rd, OP_I};
               illegal_c = !fits_signed(imm, 12) || f7b;
            end
         end
         KIND_B: begin
            word_c    = {imm[12], imm[10:5], req.rs2, req.rs1, f3, imm[4:1], imm[11], OP_B};
            illegal_c = (f3 == 3'b010) || (f3 == 3'b011) || imm[0] || !fits_signed(imm, 13);
         end
         KIND_JALR: begin
            word_c    = {imm[11:0], req.rs1, 3'b000, req.rd, OP_JALR};
            illegal_c = !fits_signed(imm, 12);
         end
         KIND_JAL: begin
            word_c    = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, OP_JAL};
            illegal_c = imm[0] || !fits_signed(imm, 21);
         end
         default: illegal_c = 1'b1;
      endcase
      if (illegal_c) word_c = NOP_WORD;
   end

endmodule

// File: rtl/instr_encoder.sv
// RV32I program loader: encodes accepted requests and writes them sequentially to
// instruction memory while holding the core, releasing it after the final write.
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int unsigned IMEM_AW = 8
) (
   input  logic               clk,
   input  logic               rst,
   instr_encoder_if.slave     req_if,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [XLEN-1:0]    imem_wdata,
   output logic               cpu_hold,
   output logic [IMEM_AW:0]   count,
   output logic               err,
   output logic [IMEM_AW-1:0] err_addr,
   output logic               err_ovf
);

   localparam int unsigned      CNT_W   = IMEM_AW + 1;
   localparam logic [IMEM_AW-1:0] PTR_MAX = '1;

   enc_state_e         state_q;
   enc_state_e         state_d;
   logic [IMEM_AW-1:0] ptr;
   enc_req_t           req;
   logic [XLEN-1:0]    word_c;
   logic               illegal_c;
   logic               ready_c;
   logic               accept_c;
   logic               at_max_c;

   assign req = '{kind:   req_if.in_kind,
                  alu_op: req_if.in_alu_op,
                  rd:     req_if.in_rd,
                  rs1:    req_if.in_rs1,
                  rs2:    req_if.in_rs2,
                  imm:    req_if.in_imm};

   assign ready_c         = (state_q == ST_LOAD) && !rst;
   assign req_if.in_ready = ready_c;
   assign accept_c        = req_if.in_valid && ready_c;
   assign at_max_c        = (ptr == PTR_MAX);

   instr_format_pack u_pack (
      .req       (req),
      .word_c    (word_c),
      .illegal_c (illegal_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_LOAD;
      else     state_q <= state_d;
   end

   // Next state: a last beat or a beat at the top address ends loading.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: if (accept_c && (req_if.in_last || at_max_c)) state_d = ST_DONE;
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_LOAD;
      endcase
   end

   // Write pipeline, pointer/count, hold release and error capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_hold   <= 1'b1;
         count      <= '0;
         err        <= 1'b0;
         err_addr   <= '0;
         err_ovf    <= 1'b0;
         ptr        <= '0;
      end else begin
         imem_we <= accept_c;
         if (accept_c) begin
            imem_addr  <= ptr;
            imem_wdata <= word_c;
            if (!at_max_c) ptr <= ptr + IMEM_AW'(1);
            if (illegal_c && !err) begin
               err      <= 1'b1;
               err_addr <= ptr;
            end
            if (at_max_c && !req_if.in_last) err_ovf <= 1'b1;
         end
         if (imem_we) count <= count + CNT_W'(1);
         // Only the final beat can still be writing once in DONE.
         if (imem_we && (state_q == ST_DONE)) cpu_hold <= 1'b0;
      end
   end

endmodule
